// File: rtl/input_port_unit.sv
`default_nettype none
// ============================================================================
// Module   : input_port_unit
// Purpose  : Router input-port front end. It holds a flit FIFO, computes the
//            XY route from the head flit, and handles switch request and packet
//            streaming.
// Revision : 1.0 - initial release
// ============================================================================
module input_port_unit #(
    parameter int DEPTH   = 4,
    parameter int X_COORD = 0,
    parameter int Y_COORD = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [33:0] in_flit,
    output logic        credit_out,
    output logic        sw_req,
    output logic [2:0]  sw_target,
    input  logic        sw_grant,
    output logic        out_valid,
    output logic [33:0] out_flit,
    input  logic        out_ready,
    output logic        err_overflow,
    output logic        err_orphan
);

    localparam int            c_AW    = $clog2(DEPTH);
    localparam logic [c_AW:0] c_DEPTH = (c_AW + 1)'(DEPTH);
    localparam logic [3:0]    c_X     = 4'(X_COORD);
    localparam logic [3:0]    c_Y     = 4'(Y_COORD);

    localparam logic [1:0] c_TYPE_HEAD = 2'b00;
    localparam logic [1:0] c_TYPE_BODY = 2'b01;
    localparam logic [1:0] c_TYPE_TAIL = 2'b10;
    localparam logic [1:0] c_TYPE_HT   = 2'b11;

    localparam logic [2:0] c_PORT_LOCAL = 3'd0;
    localparam logic [2:0] c_PORT_NORTH = 3'd1;
    localparam logic [2:0] c_PORT_SOUTH = 3'd2;
    localparam logic [2:0] c_PORT_EAST  = 3'd3;
    localparam logic [2:0] c_PORT_WEST  = 3'd4;
    localparam logic [2:0] c_PORT_NONE  = 3'd7;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_REQ    = 2'd1;
    localparam logic [1:0] c_ST_ACTIVE = 2'd2;

    logic [33:0]     r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic [1:0]      r_state;
    logic            r_sw_req;
    logic [2:0]      r_sw_target;
    logic            r_credit;
    logic            r_err_ovf;
    logic            r_err_orph;

    logic [33:0] w_front;
    logic        w_empty;
    logic        w_full;
    logic        w_front_head;
    logic        w_front_tail;
    logic        w_out_valid;
    logic        w_orphan_drop;
    logic        w_pop;
    logic        w_push;
    logic [2:0]  w_route;

    assign w_front       = r_mem[r_rd_ptr];
    assign w_empty       = (r_count == '0);
    assign w_full        = (r_count == c_DEPTH);
    assign w_front_head  = (w_front[33:32] == c_TYPE_HEAD) || (w_front[33:32] == c_TYPE_HT);
    assign w_front_tail  = (w_front[33:32] == c_TYPE_TAIL) || (w_front[33:32] == c_TYPE_HT);
    assign w_out_valid   = (r_state == c_ST_ACTIVE) && !w_empty;
    // A body/tail at the front while idle belongs to no packet: drop it.
    assign w_orphan_drop = (r_state == c_ST_IDLE) && !w_empty && !w_front_head;
    assign w_pop         = (w_out_valid && out_ready) || w_orphan_drop;
    assign w_push        = in_valid && (!w_full || w_pop);

    always_comb begin
        w_route = c_PORT_LOCAL;
        if (w_front[7:4] > c_X)      w_route = c_PORT_EAST;
        else if (w_front[7:4] < c_X) w_route = c_PORT_WEST;
        else if (w_front[3:0] > c_Y) w_route = c_PORT_NORTH;
        else if (w_front[3:0] < c_Y) w_route = c_PORT_SOUTH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_flit;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_sw_req    <= 1'b0;
            r_sw_target <= c_PORT_NONE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (!w_empty && w_front_head) begin
                        r_sw_target <= w_route;
                        r_sw_req    <= 1'b1;
                        r_state     <= c_ST_REQ;
                    end
                end
                c_ST_REQ: begin
                    if (sw_grant) begin
                        r_sw_req <= 1'b0;
                        r_state  <= c_ST_ACTIVE;
                    end
                end
                c_ST_ACTIVE: begin
                    if (w_pop && w_front_tail) begin
                        r_sw_target <= c_PORT_NONE;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= c_ST_IDLE;
                    r_sw_req    <= 1'b0;
                    r_sw_target <= c_PORT_NONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credit   <= 1'b0;
            r_err_ovf  <= 1'b0;
            r_err_orph <= 1'b0;
        end else begin
            r_credit   <= w_pop;
            r_err_ovf  <= r_err_ovf | (in_valid && w_full && !w_pop);
            r_err_orph <= r_err_orph | w_orphan_drop;
        end
    end

    assign credit_out   = r_credit;
    assign sw_req       = r_sw_req;
    assign sw_target    = r_sw_target;
    assign out_valid    = w_out_valid;
    assign out_flit     = w_front;
    assign err_overflow = r_err_ovf;
    assign err_orphan   = r_err_orph;

endmodule
`default_nettype wire

// File: tb/tb_input_port_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_port_unit
// Purpose  : Self-checking bench for input_port_unit on a router at (1,1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_input_port_unit;

    localparam int DEPTH   = 4;
    localparam int X_COORD = 1;
    localparam int Y_COORD = 1;
    localparam int N_PKT   = 40;

    localparam logic [1:0] c_HEAD = 2'b00;
    localparam logic [1:0] c_BODY = 2'b01;
    localparam logic [1:0] c_TAIL = 2'b10;
    localparam logic [1:0] c_HT   = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [33:0] in_flit;
    logic        credit_out;
    logic        sw_req;
    logic [2:0]  sw_target;
    logic        sw_grant;
    logic        out_valid;
    logic [33:0] out_flit;
    logic        out_ready;
    logic        err_overflow;
    logic        err_orphan;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    input_port_unit #(
        .DEPTH   (DEPTH),
        .X_COORD (X_COORD),
        .Y_COORD (Y_COORD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_flit      (in_flit),
        .credit_out   (credit_out),
        .sw_req       (sw_req),
        .sw_target    (sw_target),
        .sw_grant     (sw_grant),
        .out_valid    (out_valid),
        .out_flit     (out_flit),
        .out_ready    (out_ready),
        .err_overflow (err_overflow),
        .err_orphan   (err_orphan)
    );

    function automatic logic [33:0] mk(input logic [1:0] t, input int tag, input int dx, input int dy);
        return {t, 24'(tag), 4'(dx), 4'(dy)};
    endfunction

    function automatic logic is_head(input logic [33:0] f);
        return (f[33:32] == c_HEAD) || (f[33:32] == c_HT);
    endfunction

    function automatic logic is_tail(input logic [33:0] f);
        return (f[33:32] == c_TAIL) || (f[33:32] == c_HT);
    endfunction

    // X first, then Y, from the signed coordinate differences.
    function automatic logic [2:0] xy_ref(input logic [33:0] f);
        int dx;
        int dy;
        dx = int'(f[7:4]) - X_COORD;
        dy = int'(f[3:0]) - Y_COORD;
        if (dx > 0) return 3'd3;
        if (dx < 0) return 3'd4;
        if (dy > 0) return 3'd1;
        if (dy < 0) return 3'd2;
        return 3'd0;
    endfunction

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk_v(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk_b({tag, "_sw_req"}, sw_req, 1'b0);
        chk_v({tag, "_sw_target"}, 34'(sw_target), 34'd7);
        chk_b({tag, "_out_valid"}, out_valid, 1'b0);
        chk_v({tag, "_out_flit"}, out_flit, 34'd0);
        chk_b({tag, "_credit"}, credit_out, 1'b0);
        chk_b({tag, "_err_overflow"}, err_overflow, 1'b0);
        chk_b({tag, "_err_orphan"}, err_orphan, 1'b0);
    endtask

    task automatic send_ht(input string tag, input logic [33:0] f);
        cyc(); in_valid = 1'b1; in_flit = f; sw_grant = 1'b0; out_ready = 1'b0; #3;
        cyc(); in_valid = 1'b0; #3;
        chk_b({tag, "_req_early"}, sw_req, 1'b0);
        cyc(); #3;
        chk_b({tag, "_req"}, sw_req, 1'b1);
        chk_v({tag, "_target"}, 34'(sw_target), 34'(xy_ref(f)));
        sw_grant = 1'b1;
        cyc(); sw_grant = 1'b0; out_ready = 1'b1; #3;
        chk_b({tag, "_valid"}, out_valid, 1'b1);
        chk_v({tag, "_flit"}, out_flit, f);
        chk_b({tag, "_req_off"}, sw_req, 1'b0);
        cyc(); out_ready = 1'b0; #3;
        chk_b({tag, "_credit"}, credit_out, 1'b1);
        chk_b({tag, "_valid_off"}, out_valid, 1'b0);
        chk_v({tag, "_target_none"}, 34'(sw_target), 34'd7);
    endtask

    logic [33:0] pk [0:3];
    logic [33:0] ov [0:5];
    logic [33:0] src [$];
    logic [33:0] q [$];
    logic        granted;
    logic        exp_credit;
    logic        hs;
    logic        gnow;
    int          cycles;
    int          tails_seen;
    int          len;
    int          idx;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_flit = '0; sw_grant = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #4;
        chk_reset_values("rst");
        rst_n = 1'b1;

        // HEAD_TAIL to (3,1): request at cycle 2, grant at cycle 4
        cyc(); in_valid = 1'b1; in_flit = mk(c_HT, 'h10, 3, 1); #3;
        cyc(); in_valid = 1'b0; #3;
        chk_b("t1_req_c1", sw_req, 1'b0);
        cyc(); #3;
        chk_b("t1_req_c2", sw_req, 1'b1);
        chk_v("t1_target_c2", 34'(sw_target), 34'd3);
        cyc(); #3;
        chk_b("t1_valid_c3", out_valid, 1'b0);
        cyc(); sw_grant = 1'b1; #3;
        chk_b("t1_req_c4", sw_req, 1'b1);
        chk_b("t1_valid_c4", out_valid, 1'b0);
        cyc(); sw_grant = 1'b0; out_ready = 1'b1; #3;
        chk_b("t1_valid_c5", out_valid, 1'b1);
        chk_v("t1_flit_c5", out_flit, mk(c_HT, 'h10, 3, 1));
        chk_b("t1_req_c5", sw_req, 1'b0);
        cyc(); out_ready = 1'b0; #3;
        chk_b("t1_credit_c6", credit_out, 1'b1);
        chk_v("t1_target_c6", 34'(sw_target), 34'd7);
        chk_b("t1_valid_c6", out_valid, 1'b0);
        cyc(); #3;
        chk_b("t1_credit_c7", credit_out, 1'b0);

        // Four-flit packet heading SOUTH, streamed back-to-back
        pk[0] = mk(c_HEAD, 'h20, 1, 0);
        pk[1] = mk(c_BODY, 'h21, 9, 5);
        pk[2] = mk(c_BODY, 'h22, 6, 3);
        pk[3] = mk(c_TAIL, 'h23, 2, 14);
        for (int k = 0; k < 9; k++) begin
            cyc();
            in_valid = (k < 4);
            if (k < 4) in_flit = pk[k];
            sw_grant  = (k == 2);
            out_ready = (k >= 3);
            #3;
            chk_b("t2_req", sw_req, k == 2);
            chk_b("t2_valid", out_valid, (k >= 3) && (k <= 6));
            if (k >= 3 && k <= 6) chk_v("t2_flit", out_flit, pk[k-3]);
            chk_b("t2_credit", credit_out, (k >= 4) && (k <= 7));
            if (k == 2) chk_v("t2_target", 34'(sw_target), 34'd2);
            if (k == 7) chk_v("t2_target_none", 34'(sw_target), 34'd7);
        end

        send_ht("t3_west", mk(c_HT, 'h30, 0, 1));
        send_ht("t3_north", mk(c_HT, 'h31, 1, 2));
        send_ht("t3_local", mk(c_HT, 'h32, 1, 1));

        // Overflow: fifth flit dropped, then push and pop together while full
        ov[0] = mk(c_HEAD, 'h40, 2, 1);
        ov[1] = mk(c_BODY, 'h41, 0, 0);
        ov[2] = mk(c_BODY, 'h42, 0, 0);
        ov[3] = mk(c_BODY, 'h43, 0, 0);
        ov[4] = mk(c_BODY, 'h44, 0, 0);
        ov[5] = mk(c_TAIL, 'h45, 0, 0);
        for (int k = 0; k < 12; k++) begin
            cyc();
            in_valid = (k <= 4) || (k == 6);
            if (k <= 4) in_flit = ov[k];
            else if (k == 6) in_flit = ov[5];
            sw_grant  = (k == 5);
            out_ready = (k >= 6);
            #3;
            if (k == 4) chk_b("t4_ovf_before", err_overflow, 1'b0);
            if (k >= 5) chk_b("t4_ovf_sticky", err_overflow, 1'b1);
            if (k == 5) begin
                chk_b("t4_req", sw_req, 1'b1);
                chk_v("t4_target", 34'(sw_target), 34'd3);
            end
            chk_b("t4_valid", out_valid, (k >= 6) && (k <= 10));
            if (k >= 6 && k <= 10) begin
                idx = (k - 6 < 4) ? (k - 6) : 5;
                chk_v("t4_flit", out_flit, ov[idx]);
            end
            if (k == 11) chk_v("t4_target_none", 34'(sw_target), 34'd7);
        end

        // Orphan BODY into an empty FIFO
        for (int k = 0; k < 4; k++) begin
            cyc();
            in_valid = (k == 0);
            in_flit  = mk(c_BODY, 'h50, 0, 0);
            sw_grant = 1'b0; out_ready = 1'b0;
            #3;
            chk_b("t5_req", sw_req, 1'b0);
            chk_b("t5_credit", credit_out, k == 2);
            chk_b("t5_orphan", err_orphan, k >= 2);
            chk_b("t5_valid", out_valid, 1'b0);
        end

        // Reset in ACTIVE with two flits buffered
        cyc(); in_valid = 1'b1; in_flit = mk(c_HEAD, 'h60, 1, 1); #3;
        cyc(); in_flit = mk(c_BODY, 'h61, 7, 7); #3;
        cyc(); in_valid = 1'b0; #3;
        chk_b("t6_req", sw_req, 1'b1);
        chk_v("t6_target", 34'(sw_target), 34'd0);
        sw_grant = 1'b1;
        cyc(); sw_grant = 1'b0; #3;
        chk_b("t6_valid", out_valid, 1'b1);
        chk_v("t6_flit", out_flit, mk(c_HEAD, 'h60, 1, 1));
        rst_n = 1'b0;
        #1;
        chk_reset_values("t6_rst");
        cyc(); cyc(); rst_n = 1'b1; #3;
        chk_b("t6_valid_after", out_valid, 1'b0);
        cyc(); #3;
        chk_b("t6_credit_after", credit_out, 1'b0);
        chk_b("t6_req_after", sw_req, 1'b0);
        send_ht("t6_new", mk(c_HT, 'h62, 3, 1));

        // Random packets against an in-order packet model
        for (int p = 0; p < N_PKT; p++) begin
            len = int'($urandom_range(1, 4));
            if (len == 1) begin
                src.push_back(mk(c_HT, p * 16, int'($urandom_range(0, 3)), int'($urandom_range(0, 3))));
            end else begin
                src.push_back(mk(c_HEAD, p * 16, int'($urandom_range(0, 3)), int'($urandom_range(0, 3))));
                for (int b = 1; b < len - 1; b++)
                    src.push_back(mk(c_BODY, p * 16 + b, int'($urandom_range(0, 15)), int'($urandom_range(0, 15))));
                src.push_back(mk(c_TAIL, p * 16 + len - 1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15))));
            end
        end
        granted = 1'b0; exp_credit = 1'b0; cycles = 0; tails_seen = 0;
        while ((src.size() > 0 || q.size() > 0 || granted) && cycles < 4000) begin
            cyc();
            in_valid  = (src.size() > 0) && (q.size() < DEPTH) && ($urandom_range(0, 3) != 0);
            in_flit   = (src.size() > 0) ? src[0] : '0;
            out_ready = ($urandom_range(0, 3) != 0);
            sw_grant  = ($urandom_range(0, 1) != 0);
            #3;
            chk_b("rnd_credit", credit_out, exp_credit);
            chk_b("rnd_valid", out_valid, granted && (q.size() > 0));
            if (sw_req) begin
                chk_b("rnd_req_ok", !granted && (q.size() > 0) && is_head(q[0]), 1'b1);
                if (q.size() > 0) chk_v("rnd_target", 34'(sw_target), 34'(xy_ref(q[0])));
            end
            hs   = granted && (q.size() > 0) && out_ready;
            gnow = sw_req && sw_grant && !granted;
            if (hs) chk_v("rnd_flit", out_flit, q[0]);
            exp_credit = hs;
            if (hs) begin
                if (is_tail(q[0])) begin
                    granted = 1'b0;
                    tails_seen++;
                end
                void'(q.pop_front());
            end
            if (gnow) granted = 1'b1;
            if (in_valid) q.push_back(src.pop_front());
            cycles++;
        end
        chk_b("rnd_timeout", cycles < 4000, 1'b1);
        chk_v("rnd_packets", 34'(tails_seen), 34'(N_PKT));
        chk_b("rnd_err_overflow", err_overflow, 1'b0);
        chk_b("rnd_err_orphan", err_orphan, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
